// File: rtl/calc_key_pkg.sv
// Shared keypad/calculator definitions: token encoding, keypad geometry,
// active-low one-hot index helper and the row/column to token lookup.
package calc_key_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [3:0] {
        TOK_0   = 4'd0,
        TOK_1   = 4'd1,
        TOK_2   = 4'd2,
        TOK_3   = 4'd3,
        TOK_4   = 4'd4,
        TOK_5   = 4'd5,
        TOK_6   = 4'd6,
        TOK_7   = 4'd7,
        TOK_8   = 4'd8,
        TOK_9   = 4'd9,
        TOK_ADD = 4'hA,
        TOK_SUB = 4'hB,
        TOK_MUL = 4'hC,
        TOK_DIV = 4'hD,
        TOK_CLR = 4'hE,
        TOK_EQ  = 4'hF
    } calc_tok_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } onehot_idx_t;

    // Indexed by {row, col}; row 3 is the "* 0 # D" line of the keypad.
    localparam calc_tok_t TOK_LUT [ROWS*COLS] = '{
        TOK_1,   TOK_2, TOK_3,  TOK_ADD,
        TOK_4,   TOK_5, TOK_6,  TOK_SUB,
        TOK_7,   TOK_8, TOK_9,  TOK_MUL,
        TOK_CLR, TOK_0, TOK_EQ, TOK_DIV
    };

    // Position of the single zero bit counted from the MSB; valid only when
    // exactly one bit is low.
    function automatic onehot_idx_t onehot_low_idx(input logic [ROWS-1:0] pat);
        onehot_idx_t res;
        int          zeros;
        res   = '0;
        zeros = 0;
        for (int i = 0; i < ROWS; i++) begin
            if (!pat[ROWS-1-i]) begin
                zeros   = zeros + 1;
                res.idx = 2'(i);
            end
        end
        res.valid = (zeros == 1);
        return res;
    endfunction

endpackage

// File: rtl/key_decoder_if.sv
// Token handshake between the key decoder (master) and the calculator core (slave).
interface key_decoder_if;
    logic       key_valid;
    logic [3:0] key_data;
    logic       key_ready;

    modport master (output key_valid, output key_data, input  key_ready);
    modport slave  (input  key_valid, input  key_data, output key_ready);
endinterface

// File: rtl/key_fifo.sv
// First-word-fall-through token buffer; head is readable combinationally
// while fill is nonzero. Pointers wrap naturally since DEPTH is a power of two.
module key_fifo #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [3:0]       push_data,
    input  logic             pop,
    output logic [3:0]       head,
    output logic [PTR_W:0]   fill,
    output logic             full,
    output logic             empty
);

    logic [3:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   fill_reg;
    logic             wr_en;
    logic             rd_en;

    assign empty = (fill_reg == '0);
    assign full  = (fill_reg == (PTR_W+1)'(DEPTH));
    // A push into a full buffer only lands if the head leaves on the same edge.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   fill_reg <= fill_reg + 1'b1;
                2'b01:   fill_reg <= fill_reg - 1'b1;
                default: fill_reg <= fill_reg;
            endcase
        end
    end

    assign head = mem[rd_ptr_reg];
    assign fill = fill_reg;

endmodule

// File: rtl/key_decoder.sv
// Keypad pattern validation, token translation and buffering toward the calculator.
// Optional saturating error counter enabled by KEYDEC_ERRCNT_EN.
module key_decoder
    import calc_key_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ev,
    input  logic [3:0]         row_i,
    input  logic [3:0]         col_i,
    key_decoder_if.master      kif,
    output logic [PTR_W:0]     fill,
    output logic               overflow,
    output logic               bad_key,
    output logic [7:0]         err_count
);

    onehot_idx_t row_dec;
    onehot_idx_t col_dec;
    logic        pattern_ok;

    calc_tok_t   dec_tok_reg;
    logic        dec_push_reg;
    logic        dec_bad_reg;
    logic        bad_key_reg;
    logic        overflow_reg;
    logic [3:0]  key_data_hold_reg;
    logic [3:0]  key_data_next;

    logic [3:0]  fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        dropped;

    assign row_dec    = onehot_low_idx(row_i);
    assign col_dec    = onehot_low_idx(col_i);
    assign pattern_ok = row_dec.valid && col_dec.valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec_tok_reg  <= TOK_0;
            dec_push_reg <= 1'b0;
            dec_bad_reg  <= 1'b0;
        end else begin
            dec_tok_reg  <= TOK_LUT[{row_dec.idx, col_dec.idx}];
            dec_push_reg <= ev && pattern_ok;
            dec_bad_reg  <= ev && !pattern_ok;
        end
    end

    assign pop     = kif.key_valid && kif.key_ready;
    assign dropped = dec_push_reg && fifo_full && !pop;

    key_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (dec_push_reg),
        .push_data (dec_tok_reg),
        .pop       (pop),
        .head      (fifo_head),
        .fill      (fill),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Consumer sees the last token again once the buffer has drained.
    assign key_data_next = fifo_empty ? key_data_hold_reg : fifo_head;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bad_key_reg       <= 1'b0;
            overflow_reg      <= 1'b0;
            key_data_hold_reg <= 4'h0;
        end else begin
            bad_key_reg       <= dec_bad_reg;
            overflow_reg      <= overflow_reg || dropped;
            key_data_hold_reg <= key_data_next;
        end
    end

    assign kif.key_valid = !fifo_empty;
    assign kif.key_data  = key_data_next;
    assign bad_key       = bad_key_reg;
    assign overflow      = overflow_reg;

`ifdef KEYDEC_ERRCNT_EN
    logic [7:0] err_cnt_reg;

    // Bad pattern and drop share one increment when they coincide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_reg <= 8'h00;
        end else if ((dec_bad_reg || dropped) && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'h01;
        end
    end

    assign err_count = err_cnt_reg;
`else
    assign err_count = 8'h00;
`endif

endmodule
